// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: debounces set/clear buttons and sequences timed s/r
// pulses into a downstream SR flip-flop, verifying q_fb after each command.

// Per-button front end: 2-flop synchronizer, stability debouncer and
// rising-edge detector on the debounced level.
module sr_btn_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       deb_q, deb_d;
  logic       deb_dly_q, deb_dly_d;
  logic [7:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized level disagrees with the
  // accepted level; any agreement restarts the stability window.
  always_comb begin
    sync1_d   = btn;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    cnt_d     = 8'd0;
    if (sync2_q != deb_q) begin
      if (cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Front-end state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rise = deb_q & ~deb_dly_q;
endmodule

module sr_cmd_sequencer #(
  parameter int DEB_CYCLES   = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_btn,
  input  logic             clr_btn,
  input  logic             q_fb,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cmd_count
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] CHECK  = 2'd3;

  localparam int SET_I = 0;
  localparam int CLR_I = 1;
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

  logic [1:0] btn, rise;

  assign btn = {clr_btn, set_btn};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    sr_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn[i]),
      .rise (rise[i])
    );
  end

  logic [1:0]       state_q, state_d;
  logic [1:0]       pend_q, pend_d;
  logic             is_set_q, is_set_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Command FSM: accept (clear wins), drive pulse, settle, check readback.
  // done/count/err all update on the edge leaving CHECK so they appear
  // together in the following cycle.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q | rise;
    is_set_d = is_set_q;
    pcnt_d   = pcnt_q;
    s_d      = s_q;
    r_d      = r_q;
    done_d   = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pend_q[CLR_I]) begin
          pend_d[CLR_I] = rise[CLR_I];
          is_set_d      = 1'b0;
          r_d           = 1'b1;
          s_d           = 1'b0;
          pcnt_d        = 4'd0;
          state_d       = DRIVE;
        end else if (pend_q[SET_I]) begin
          pend_d[SET_I] = rise[SET_I];
          is_set_d      = 1'b1;
          s_d           = 1'b1;
          r_d           = 1'b0;
          pcnt_d        = 4'd0;
          state_d       = DRIVE;
        end
      end
      DRIVE: begin
        if (pcnt_q == PULSE_LAST) begin
          s_d     = 1'b0;
          r_d     = 1'b0;
          state_d = SETTLE;
        end else begin
          pcnt_d = pcnt_q + 4'd1;
        end
      end
      SETTLE: state_d = CHECK;
      CHECK: begin
        done_d  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (q_fb != is_set_q) err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; reset drops s/r immediately and discards any command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_q   <= 2'b00;
      is_set_q <= 1'b0;
      pcnt_q   <= 4'd0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      is_set_q <= is_set_d;
      pcnt_q   <= pcnt_d;
      s_q      <= s_d;
      r_q      <= r_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign cmd_count = cnt_q;
endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Bench for sr_cmd_sequencer: directed scenarios plus randomized commands,
// checked against a transaction-level model of pulse timing, count and err.
module tb_sr_cmd_sequencer;
  localparam int DEB = 4;
  localparam int PUL = 2;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          set_btn = 1'b0;
  logic          clr_btn = 1'b0;
  logic          q_fb;
  logic          s, r, busy, done, err;
  logic [CW-1:0] cmd_count;

  sr_cmd_sequencer #(.DEB_CYCLES(DEB), .PULSE_CYCLES(PUL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .clr_btn(clr_btn),
    .q_fb(q_fb), .s(s), .r(r), .busy(busy), .done(done), .err(err),
    .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // Downstream SR flip-flop model, optionally overridden by a tied value.
  logic ff_q = 1'b0;
  bit   tie_en = 1'b0;
  bit   tie_val = 1'b0;
  always @(posedge clk) ff_q <= s ? 1'b1 : (r ? 1'b0 : ff_q);
  assign q_fb = tie_en ? tie_val : ff_q;

  int errors = 0, checks = 0;
  int exp_cnt = 0;
  bit exp_err = 1'b0;
  int done_seen = 0, s_rises = 0;
  logic s_prev = 1'b0;
  int lat, n, d0, which, h;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    assert (got === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample just after the edge; s/r exclusivity is
  // checked on every sampled cycle.
  task automatic tick();
    @(posedge clk); #1;
    chk("excl_sr", {31'd0, ~(s & r)}, 1);
    if (done === 1'b1) done_seen++;
    if (s === 1'b1 && s_prev !== 1'b1) s_rises++;
    s_prev = s;
  endtask

  // which: 0=set, 1=clr, 2=both. Held for n sampling edges.
  task automatic hold(input int w, input int cyc);
    if (w != 1) set_btn = 1'b1;
    if (w != 0) clr_btn = 1'b1;
    repeat (cyc) @(posedge clk);
    #1;
    set_btn = 1'b0;
    clr_btn = 1'b0;
  endtask

  // Wait for a command to start, then check its whole life against the model.
  task automatic run_cmd(input bit exp_set, output int latency);
    int k = 0;
    bit qv;
    while (!(s === 1'b1 || r === 1'b1) && k < 60) begin tick(); k++; end
    latency = k;
    chk("cmd_start", {31'd0, (s | r)}, 1);
    chk("cmd_s", {31'd0, s}, exp_set);
    chk("cmd_r", {31'd0, r}, !exp_set);
    chk("busy_drive", {31'd0, busy}, 1);
    for (int i = 1; i < PUL; i++) begin
      tick();
      chk("pulse_s", {31'd0, s}, exp_set);
      chk("pulse_r", {31'd0, r}, !exp_set);
    end
    tick();
    chk("settle_s", {31'd0, s}, 0);
    chk("settle_r", {31'd0, r}, 0);
    chk("settle_done", {31'd0, done}, 0);
    tick();
    chk("check_done_early", {31'd0, done}, 0);
    chk("busy_check", {31'd0, busy}, 1);
    qv = tie_en ? tie_val : exp_set;
    if (qv != exp_set) exp_err = 1'b1;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    tick();
    chk("done", {31'd0, done}, 1);
    chk("cmd_count", {30'd0, cmd_count}, exp_cnt);
    chk("err", {31'd0, err}, exp_err);
    tick();
    chk("done_pulse", {31'd0, done}, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_s", {31'd0, s}, 0);
    chk("rst_r", {31'd0, r}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_count", {30'd0, cmd_count}, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Clean set press, q_fb follows s
    fork hold(0, 10); join_none
    run_cmd(1'b1, lat);
    chk("lat_set", lat, DEB + 4);
    repeat (20) tick();
    chk("set_rises", s_rises, 1);

    // Short glitch is filtered
    fork hold(0, 2); join_none
    repeat (30) tick();
    chk("glitch_rises", s_rises, 1);
    chk("glitch_count", {30'd0, cmd_count}, exp_cnt);
    chk("glitch_busy", {31'd0, busy}, 0);

    // Simultaneous presses: clear first, set follows with no gap
    fork hold(2, 10); join_none
    run_cmd(1'b0, lat);
    run_cmd(1'b1, lat);
    chk("no_gap", lat, 0);
    repeat (20) tick();

    // Clear with q_fb stuck high: err sticks through a later good set
    tie_en = 1'b1; tie_val = 1'b1;
    fork hold(1, 6); join_none
    run_cmd(1'b0, lat);
    chk("err_set", {31'd0, err}, 1);
    repeat (20) tick();
    tie_en = 1'b0;
    fork hold(0, 6); join_none
    run_cmd(1'b1, lat);
    chk("err_sticky", {31'd0, err}, 1);
    repeat (20) tick();

    // Reset during DRIVE
    fork hold(0, 6); join_none
    n = 0;
    while (s !== 1'b1 && n < 40) begin tick(); n++; end
    chk("rst_wait_s", {31'd0, s}, 1);
    d0 = done_seen;
    #2 rst_n = 1'b0;
    #1;
    chk("async_s", {31'd0, s}, 0);
    chk("async_r", {31'd0, r}, 0);
    chk("async_busy", {31'd0, busy}, 0);
    tick(); tick();
    chk("midrst_count", {30'd0, cmd_count}, 0);
    chk("midrst_err", {31'd0, err}, 0);
    exp_cnt = 0; exp_err = 1'b0;
    rst_n = 1'b1;
    repeat (25) tick();
    chk("midrst_no_done", done_seen, d0);
    chk("midrst_count2", {30'd0, cmd_count}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);

    // Button held through reset release is a fresh edge
    rst_n = 1'b0; set_btn = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    run_cmd(1'b1, lat);
    chk("lat_held", lat, DEB + 4);
    set_btn = 1'b0;
    repeat (20) tick();

    // Counter wrap with CNT_W=2: 1,2,3,0,1
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    exp_cnt = 0; exp_err = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      fork hold(0, 6); join_none
      run_cmd(1'b1, lat);
      chk("wrap_seq", {30'd0, cmd_count}, (i + 1) % 4);
      repeat (20) tick();
    end

    // Randomized commands and readback faults
    for (int i = 0; i < 12; i++) begin
      which   = int'($urandom_range(0, 1));
      tie_en  = bit'($urandom_range(0, 1));
      tie_val = bit'($urandom_range(0, 1));
      h       = int'($urandom_range(4, 9));
      fork hold(which, h); join_none
      run_cmd(which == 0, lat);
      chk("lat_rand", lat, DEB + 4);
      repeat ($urandom_range(15, 25)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
